note_tone_detector: RTL and testbench

NOTE_TONE_DETECTOR -- requirements
Module: note_tone_detector

---
 rtl/note_tone_detector.sv | 183 ++++++++++++++++++
 tb/tb_note_tone_detector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/note_tone_detector.sv
// Note tone detector: measures the period of a synchronized square wave and locks
// onto one of three nominal note periods after MATCH_COUNT consecutive matches.
module note_tone_detector #(
    parameter int TOL         = 64,
    parameter int MATCH_COUNT = 3,
    parameter int TIMEOUT     = 131071,
    parameter int C_NOM       = 97123,
    parameter int D_NOM       = 86817,
    parameter int F_NOM       = 72975
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic        note_valid,
    output logic [1:0]  note_id,
    output logic [2:0]  note_onehot,
    output logic        new_note,
    output logic [20:0] period_out
);

    localparam logic [20:0] CNT_MAX   = '1;
    localparam logic [20:0] TIMEOUT_C = 21'(TIMEOUT);
    localparam logic [7:0]  MATCH_C   = 8'(MATCH_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    function automatic logic within_tol(input logic [20:0] p, input int nom);
        logic signed [22:0] d;
        d = $signed({2'b00, p}) - $signed(23'(nom));
        return (d <= $signed(23'(TOL))) && (d >= -$signed(23'(TOL)));
    endfunction

    function automatic logic [1:0] classify(input logic [20:0] p);
        if (within_tol(p, C_NOM))      return 2'd1;
        else if (within_tol(p, D_NOM)) return 2'd2;
        else if (within_tol(p, F_NOM)) return 2'd3;
        else                           return 2'd0;
    endfunction

    logic        sync1, sync2, prev;
    logic [20:0] cnt;
    logic        rise, timeout;
    logic        vld_p1;
    logic [20:0] period_p1;
    logic [1:0]  cls;
    logic [7:0]  m_inc;

    state_t      state, state_n;
    logic [1:0]  cand, cand_n;
    logic [7:0]  mcnt, mcnt_n;
    logic        valid_n, new_n;
    logic [1:0]  id_n;
    logic [2:0]  onehot_n;
    logic [20:0] pout_n;

    assign rise    = sync2 & ~prev;
    // An edge already in flight to the FSM takes priority over a timeout.
    assign timeout = (state != IDLE) && !rise && !vld_p1 && (cnt >= TIMEOUT_C);

    // Stage 0: synchronizer, edge detect and period counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            cnt    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            sync1  <= tone_in;
            sync2  <= sync1;
            prev   <= sync2;
            vld_p1 <= rise;
            if (rise)
                cnt <= 21'd1;
            else if (timeout || (state == IDLE && !vld_p1))
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 21'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rise)
            period_p1 <= cnt;
    end

    // Stage 1: classify the completed period and run the lock FSM
    assign cls   = classify(period_p1);
    assign m_inc = (cls == cand) ? mcnt + 8'd1 : 8'd1;

    always_comb begin
        state_n = state;
        cand_n  = cand;
        mcnt_n  = mcnt;
        valid_n = note_valid;
        id_n    = note_id;
        new_n   = 1'b0;
        pout_n  = period_out;
        case (state)
            IDLE: begin
                if (vld_p1)
                    state_n = MEASURE;
            end
            MEASURE: begin
                if (vld_p1) begin
                    pout_n = period_p1;
                    if (cls != 2'd0) begin
                        cand_n = cls;
                        mcnt_n = m_inc;
                        if (m_inc >= MATCH_C) begin
                            state_n = LOCKED;
                            id_n    = cls;
                            valid_n = 1'b1;
                            new_n   = 1'b1;
                        end
                    end else begin
                        mcnt_n = '0;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    mcnt_n  = '0;
                    id_n    = '0;
                    valid_n = 1'b0;
                end
            end
            LOCKED: begin
                if (vld_p1) begin
                    pout_n = period_p1;
                    if (cls == 2'd0) begin
                        state_n = MEASURE;
                        mcnt_n  = '0;
                        id_n    = '0;
                        valid_n = 1'b0;
                    end else if (cls != note_id) begin
                        id_n   = cls;
                        cand_n = cls;
                        mcnt_n = 8'd1;
                        new_n  = 1'b1;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    mcnt_n  = '0;
                    id_n    = '0;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        onehot_n = 3'b000;
        if (valid_n) begin
            case (id_n)
                2'd1:    onehot_n = 3'b001;
                2'd2:    onehot_n = 3'b010;
                2'd3:    onehot_n = 3'b100;
                default: onehot_n = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cand        <= '0;
            mcnt        <= '0;
            note_valid  <= 1'b0;
            note_id     <= '0;
            note_onehot <= '0;
            new_note    <= 1'b0;
            period_out  <= '0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            mcnt        <= mcnt_n;
            note_valid  <= valid_n;
            note_id     <= id_n;
            note_onehot <= onehot_n;
            new_note    <= new_n;
            period_out  <= pout_n;
        end
    end

endmodule

// File: tb/tb_note_tone_detector.sv
// Directed bench for note_tone_detector, using scaled-down nominal periods so the
// whole run stays short; tolerance and timeout are scaled with them.
module tb_note_tone_detector;

    localparam int TOL     = 8;
    localparam int MC      = 3;
    localparam int TIMEOUT = 1400;
    localparam int CP      = 971;
    localparam int DP      = 868;
    localparam int FP      = 730;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tone_in = 1'b0;
    logic        note_valid;
    logic [1:0]  note_id;
    logic [2:0]  note_onehot;
    logic        new_note;
    logic [20:0] period_out;

    int checks = 0;
    int passed = 0;
    int nn_count = 0;

    note_tone_detector #(
        .TOL(TOL), .MATCH_COUNT(MC), .TIMEOUT(TIMEOUT),
        .C_NOM(CP), .D_NOM(DP), .F_NOM(FP)
    ) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in),
        .note_valid(note_valid), .note_id(note_id), .note_onehot(note_onehot),
        .new_note(new_note), .period_out(period_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (new_note) nn_count <= nn_count + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One full square-wave period starting with a rising edge.
    task automatic cycle(input int n);
        tone_in = 1'b1;
        repeat (n / 2) @(negedge clk);
        tone_in = 1'b0;
        repeat (n - n / 2) @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic v, input logic [1:0] id,
                              input logic [2:0] oh, input logic [20:0] po);
        checks++;
        if (note_valid !== v || note_id !== id || note_onehot !== oh || period_out !== po)
            $display("FAIL %s: got valid=%b id=%0d onehot=%b period=%0d, want valid=%b id=%0d onehot=%b period=%0d",
                     name, note_valid, note_id, note_onehot, period_out, v, id, oh, po);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        check_outs("reset_outputs", 1'b0, 2'd0, 3'b000, 21'd0);
        checks++;
        if (new_note !== 1'b0) $display("FAIL reset_new_note: got %b want 0", new_note);
        else passed++;
    endtask

    task automatic test_c_sharp();
        int base;
        do_reset();
        base = nn_count;
        repeat (3) cycle(CP);
        tone_in = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("c_before_latency", 1'b0, 2'd0, 3'b000, 21'(CP));
        @(negedge clk);
        check_outs("c_lock", 1'b1, 2'd1, 3'b001, 21'(CP));
        checks++;
        if (new_note !== 1'b1) $display("FAIL c_new_note_pulse: got %b want 1", new_note);
        else passed++;
        repeat (CP / 2 - 4) @(negedge clk);
        tone_in = 1'b0;
        repeat (CP - CP / 2) @(negedge clk);
        cycle(CP);
        tone_in = 1'b1;
        repeat (6) @(negedge clk);
        check_outs("c_hold", 1'b1, 2'd1, 3'b001, 21'(CP));
        checks++;
        if (nn_count - base !== 1) $display("FAIL c_pulse_count: got %0d want 1", nn_count - base);
        else passed++;
        tone_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = nn_count;
        repeat (3) cycle(FP);
        cycle(DP);
        check_outs("f_lock", 1'b1, 2'd3, 3'b100, 21'(FP));
        tone_in = 1'b1;
        repeat (4) @(negedge clk);
        check_outs("f_to_d_switch", 1'b1, 2'd2, 3'b010, 21'(DP));
        repeat (4) @(negedge clk);
        checks++;
        if (nn_count - base !== 2) $display("FAIL f_d_pulse_count: got %0d want 2", nn_count - base);
        else passed++;
        tone_in = 1'b0;
    endtask

    task automatic test_tolerance();
        do_reset();
        repeat (3) cycle(CP + TOL);
        tone_in = 1'b1;
        repeat (4) @(negedge clk);
        check_outs("tol_inside_locks", 1'b1, 2'd1, 3'b001, 21'(CP + TOL));
        do_reset();
        repeat (4) cycle(CP + TOL + 1);
        tone_in = 1'b1;
        repeat (4) @(negedge clk);
        check_outs("tol_outside_no_lock", 1'b0, 2'd0, 3'b000, 21'(CP + TOL + 1));
        tone_in = 1'b0;
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        repeat (3) cycle(DP);
        tone_in = 1'b1;
        k = 0;
        repeat (DP / 2) begin
            @(negedge clk);
            k++;
        end
        tone_in = 1'b0;
        check_outs("d_lock_before_timeout", 1'b1, 2'd2, 3'b010, 21'(DP));
        while (note_valid === 1'b1 && k < 3 * TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== TIMEOUT + 3) $display("FAIL timeout_cycle: valid fell after %0d cycles want %0d", k, TIMEOUT + 3);
        else passed++;
        check_outs("timeout_outputs", 1'b0, 2'd0, 3'b000, 21'(DP));
        // Back in IDLE, the next edge starts a fresh measurement and yields no period.
        cycle(FP);
        tone_in = 1'b1;
        repeat (4) @(negedge clk);
        check_outs("idle_after_timeout", 1'b0, 2'd0, 3'b000, 21'(FP));
        tone_in = 1'b0;
    endtask

    task automatic test_reset_midlock();
        do_reset();
        repeat (3) cycle(FP);
        tone_in = 1'b1;
        repeat (FP / 2) @(negedge clk);
        tone_in = 1'b0;
        check_outs("f_locked_pre_rst", 1'b1, 2'd3, 3'b100, 21'(FP));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outs("rst_midlock_clear", 1'b0, 2'd0, 3'b000, 21'd0);
        repeat (3) @(negedge clk);
        repeat (3) cycle(FP);
        check_outs("relock_not_yet", 1'b0, 2'd0, 3'b000, 21'(FP));
        tone_in = 1'b1;
        repeat (4) @(negedge clk);
        check_outs("relock_4th_edge", 1'b1, 2'd3, 3'b100, 21'(FP));
        tone_in = 1'b0;
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        base = nn_count;
        repeat (4) begin
            cycle(500);
            cycle(CP);
        end
        tone_in = 1'b1;
        repeat (4) @(negedge clk);
        check_outs("glitch_no_lock", 1'b0, 2'd0, 3'b000, 21'(CP));
        checks++;
        if (nn_count - base !== 0) $display("FAIL glitch_pulses: got %0d want 0", nn_count - base);
        else passed++;
        tone_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_c_sharp();
        test_back_to_back();
        test_tolerance();
        test_timeout();
        test_reset_midlock();
        test_glitch();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
